// File: rtl/chad_mem_pkg.sv
// Shared memory constants and helpers for spram_arb / spram_be.
// SPRAM_ARB_OREG_EN selects the read latency constant RD_LAT (2 when defined, else 1).
package chad_mem_pkg;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

`ifdef SPRAM_ARB_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    function automatic int nlanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/spram_be.sv
// Single-port RAM with byte-lane write enables and registered read, shaped for BRAM inference.
module spram_be
    import chad_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    localparam int NLANES    = nlanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [NLANES-1:0]     be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write lanes or capture read word; the read register is only loaded on reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (be[i]) begin
                        mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign dout = rdata_q;

endmodule

// File: rtl/spram_arb.sv
// Two-requester front end (A priority, B starvation-guarded) over spram_be.
// SPRAM_ARB_OREG_EN adds an output register stage: read latency 2 instead of 1.
module spram_arb
    import chad_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int STARVE_MAX = 4,
    localparam int NLANES    = nlanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [NLANES-1:0]     a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [NLANES-1:0]     b_be,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_rvalid,
    output logic                  b_hold
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]         starve_q, starve_d;
    logic                  force_b;
    logic                  ram_en, ram_we, rd_issue;
    logic [NLANES-1:0]     ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din, ram_rdata;
    logic                  p1_vld_q, p1_own_q;
    logic                  out_vld, out_own;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] a_dout_q, b_dout_q;

    assign force_b = (starve_q == SW'(STARVE_MAX));

    // Fixed priority to A unless B has been denied STARVE_MAX cycles in a row.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (force_b && b_req) begin
            b_gnt = 1'b1;
        end else if (a_req) begin
            a_gnt = 1'b1;
        end else if (b_req) begin
            b_gnt = 1'b1;
        end else begin
            b_gnt = 1'b0;
        end
    end

    assign b_hold = b_req & ~b_gnt;

    // Starve count climbs on each denied B cycle, saturates, clears otherwise.
    always_comb begin
        starve_d = '0;
        if (b_req && !b_gnt) begin
            if (force_b) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end else begin
            starve_d = '0;
        end
    end

    assign ram_en   = a_gnt | b_gnt;
    assign ram_we   = b_gnt ? b_we   : a_we;
    assign ram_be   = b_gnt ? b_be   : a_be;
    assign ram_addr = b_gnt ? b_addr : a_addr;
    assign ram_din  = b_gnt ? b_din  : a_din;
    assign rd_issue = ram_en & ~ram_we;

    spram_be #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_rdata)
    );

    // Starve counter and first read-tracking stage (owner recorded at the grant edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            p1_vld_q <= 1'b0;
            p1_own_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            p1_vld_q <= rd_issue;
            p1_own_q <= b_gnt;
        end
    end

`ifdef SPRAM_ARB_OREG_EN
    logic                  p2_vld_q, p2_own_q;
    logic [DATA_WIDTH-1:0] oreg_q;

    // Extra output register stage; tracking bits follow the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_vld_q <= 1'b0;
            p2_own_q <= 1'b0;
            oreg_q   <= '0;
        end else begin
            p2_vld_q <= p1_vld_q;
            p2_own_q <= p1_own_q;
            oreg_q   <= ram_rdata;
        end
    end

    assign out_vld  = p2_vld_q;
    assign out_own  = p2_own_q;
    assign out_data = oreg_q;
`else
    assign out_vld  = p1_vld_q;
    assign out_own  = p1_own_q;
    assign out_data = ram_rdata;
`endif

    assign a_rvalid = out_vld & (out_own == 1'(PORT_A));
    assign b_rvalid = out_vld & (out_own == 1'(PORT_B));

    // Per-port hold registers keep the last completed read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= a_rvalid ? out_data : a_dout_q;
            b_dout_q <= b_rvalid ? out_data : b_dout_q;
        end
    end

    assign a_dout = a_rvalid ? out_data : a_dout_q;
    assign b_dout = b_rvalid ? out_data : b_dout_q;

endmodule
